// File: rtl/pop_pkg.sv
// Shared constants and FSM state type for the frame statistics stage.
package pop_pkg;

   localparam int WORD_W = 32;
   localparam int POP_W  = 6;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : pop_pkg

// File: rtl/count32.sv
// Combinational 32-bit population count (0..32).
module count32
   import pop_pkg::*;
(
   input  logic [WORD_W-1:0] data,
   output logic [POP_W-1:0]  count
);

   // Sum every bit of the word into a 6-bit result.
   always_comb begin
      count = 6'd0;
      for (int i = 0; i < WORD_W; i++) begin
         count = count + {5'd0, data[i]};
      end
   end

endmodule : count32

// File: rtl/pop_frame_stats.sv
// Per-frame popcount statistics: sum of set bits, word count and largest
// per-word count, with saturating accumulators and a sticky overflow flag.
module pop_frame_stats
   import pop_pkg::*;
#(
   parameter  int CNT_W = 16,
   localparam int SUM_W = CNT_W + 5
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_words,
   output logic [5:0]        out_max,
   output logic              out_overflow
);

   state_t             state_r;
   state_t             state_nxt_s;
   logic               accept_s;
   logic [POP_W-1:0]   cnt_s;
   logic [POP_W-1:0]   p1_cnt_r;
   logic               p1_last_r;
   logic               p1_valid_r;
   logic [SUM_W-1:0]   sum_r;
   logic [CNT_W-1:0]   words_r;
   logic [POP_W-1:0]   max_r;
   logic               ovf_r;
   logic [SUM_W:0]     sum_ext_s;
   logic [SUM_W-1:0]   sum_sat_s;
   logic               words_full_s;
   logic               result_taken_s;

   count32 u_count32 (
      .data  (in_data),
      .count (cnt_s)
   );

   assign accept_s       = in_valid && in_ready;
   assign result_taken_s = (state_r == DONE) && out_ready;

   // Widened add so a carry out of the sum is visible for saturation.
   assign sum_ext_s    = {1'b0, sum_r} + {{(SUM_W + 1 - POP_W){1'b0}}, p1_cnt_r};
   assign sum_sat_s    = sum_ext_s[SUM_W] ? {SUM_W{1'b1}} : sum_ext_s[SUM_W-1:0];
   assign words_full_s = &words_r;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and handshake decode; DRAIN holds until the last word has left stage 1.
   always_comb begin
      state_nxt_s = state_r;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (state_r)
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (p1_valid_r && p1_last_r) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = RUN;
         end
      endcase
   end

   // Stage 1: register the popcount of each accepted word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_cnt_r   <= 6'd0;
         p1_last_r  <= 1'b0;
         p1_valid_r <= 1'b0;
      end else if (accept_s) begin
         p1_cnt_r   <= cnt_s;
         p1_last_r  <= in_last;
         p1_valid_r <= 1'b1;
      end else begin
         p1_valid_r <= 1'b0;
      end
   end

   // Stage 2: saturating frame accumulators, cleared when the result is taken.
   always_ff @(posedge clk) begin
      if (!rst_n || result_taken_s) begin
         sum_r   <= {SUM_W{1'b0}};
         words_r <= {CNT_W{1'b0}};
         max_r   <= 6'd0;
         ovf_r   <= 1'b0;
      end else if (p1_valid_r) begin
         sum_r   <= sum_sat_s;
         words_r <= words_full_s ? words_r : (words_r + {{(CNT_W-1){1'b0}}, 1'b1});
         max_r   <= (p1_cnt_r > max_r) ? p1_cnt_r : max_r;
         ovf_r   <= ovf_r | sum_ext_s[SUM_W] | words_full_s;
      end else begin
         ovf_r   <= ovf_r;
      end
   end

   assign out_sum      = sum_r;
   assign out_words    = words_r;
   assign out_max      = max_r;
   assign out_overflow = ovf_r;

endmodule : pop_frame_stats

// File: tb/tb_pop_frame_stats.sv
// Directed bench: a default instance (CNT_W=16) and a narrow instance
// (CNT_W=2) share the stimulus; the narrow one exercises saturation.
module tb_pop_frame_stats;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [20:0] out_sum;
   logic [15:0] out_words;
   logic [5:0]  out_max;
   logic        out_overflow;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [6:0]  s_out_sum;
   logic [1:0]  s_out_words;
   logic [5:0]  s_out_max;
   logic        s_out_overflow;

   int checks = 0;
   int errors = 0;

   pop_frame_stats dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_words    (out_words),
      .out_max      (out_max),
      .out_overflow (out_overflow)
   );

   pop_frame_stats #(.CNT_W(2)) dut_s (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (s_in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (s_out_valid),
      .out_ready    (out_ready),
      .out_sum      (s_out_sum),
      .out_words    (s_out_words),
      .out_max      (s_out_max),
      .out_overflow (s_out_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word; it is accepted at the next rising edge.
   task automatic send_word(input logic [31:0] d, input logic l);
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_data  = 32'd0;
      in_last  = 1'b0;
   endtask

   task automatic chk_result(input string tag, input logic [31:0] s, input logic [31:0] w,
                             input logic [31:0] m, input logic [31:0] o);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_sum"},   {11'd0, out_sum}, s);
      chk({tag, "_words"}, {16'd0, out_words}, w);
      chk({tag, "_max"},   {26'd0, out_max}, m);
      chk({tag, "_ovf"},   {31'd0, out_overflow}, o);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum",       {11'd0, out_sum}, 32'd0);
      chk("rst_words",     {16'd0, out_words}, 32'd0);
      chk("rst_max",       {26'd0, out_max}, 32'd0);
      chk("rst_ovf",       {31'd0, out_overflow}, 32'd0);

      // Basic frame, back-to-back words
      send_word(32'h0000_0000, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0);
      send_word(32'hFFFF_0000, 1'b1);
      chk("basic_valid_t0", {31'd0, out_valid}, 32'd0);
      chk("basic_ready_t0", {31'd0, in_ready}, 32'd0);
      tick();
      chk("basic_valid_t1", {31'd0, out_valid}, 32'd0);
      tick();
      chk_result("basic", 32'd49, 32'd4, 32'd32, 32'd0);
      tick();
      chk("basic_valid_1cyc", {31'd0, out_valid}, 32'd0);
      chk("basic_ready_back", {31'd0, in_ready}, 32'd1);

      // Single-word frame
      send_word(32'h0000_000F, 1'b1);
      chk("single_ready_drain", {31'd0, in_ready}, 32'd0);
      tick();
      chk("single_ready_drain2", {31'd0, in_ready}, 32'd0);
      tick();
      chk_result("single", 32'd4, 32'd1, 32'd4, 32'd0);
      chk("single_ready_done", {31'd0, in_ready}, 32'd0);
      tick();
      chk("single_ready_back", {31'd0, in_ready}, 32'd1);

      // Backpressure on the result
      out_ready = 1'b0;
      send_word(32'h0000_0000, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0);
      send_word(32'hFFFF_0000, 1'b1);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk_result("bp_hold", 32'd49, 32'd4, 32'd32, 32'd0);
         chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
         tick();
      end
      chk_result("bp_still", 32'd49, 32'd4, 32'd32, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("bp_ready_back", {31'd0, in_ready}, 32'd1);

      // Frame A with gaps, then frame B straight after the handshake
      send_word(32'hAAAA_AAAA, 1'b0);
      tick();
      tick();
      send_word(32'h0000_0001, 1'b1);
      tick();
      tick();
      chk_result("frameA", 32'd17, 32'd2, 32'd16, 32'd0);
      tick();
      send_word(32'h8000_0000, 1'b1);
      tick();
      tick();
      chk_result("frameB", 32'd1, 32'd1, 32'd1, 32'd0);
      tick();

      // Saturation on the narrow instance
      for (int i = 0; i < 5; i++) begin
         send_word(32'hFFFF_FFFF, (i == 4) ? 1'b1 : 1'b0);
      end
      tick();
      tick();
      chk("ovf_s_valid", {31'd0, s_out_valid}, 32'd1);
      chk("ovf_s_words", {30'd0, s_out_words}, 32'd3);
      chk("ovf_s_sum",   {25'd0, s_out_sum}, 32'd127);
      chk("ovf_s_max",   {26'd0, s_out_max}, 32'd32);
      chk("ovf_s_flag",  {31'd0, s_out_overflow}, 32'd1);
      chk_result("ovf_wide", 32'd160, 32'd5, 32'd32, 32'd0);
      tick();
      send_word(32'h0000_0001, 1'b1);
      tick();
      tick();
      chk("post_ovf_s_valid", {31'd0, s_out_valid}, 32'd1);
      chk("post_ovf_s_sum",   {25'd0, s_out_sum}, 32'd1);
      chk("post_ovf_s_words", {30'd0, s_out_words}, 32'd1);
      chk("post_ovf_s_max",   {26'd0, s_out_max}, 32'd1);
      chk("post_ovf_s_flag",  {31'd0, s_out_overflow}, 32'd0);
      tick();

      // Reset in the middle of a frame
      send_word(32'hFFFF_FFFF, 1'b0);
      send_word(32'hFFFF_FFFF, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_sum",   {11'd0, out_sum}, 32'd0);
      chk("mid_rst_words", {16'd0, out_words}, 32'd0);
      tick();
      chk("mid_rst_sum2",  {11'd0, out_sum}, 32'd0);
      send_word(32'h0000_0003, 1'b1);
      chk("mid_rst_no_stale", {31'd0, out_valid}, 32'd0);
      tick();
      chk("mid_rst_no_stale2", {31'd0, out_valid}, 32'd0);
      tick();
      chk_result("after_rst", 32'd2, 32'd1, 32'd2, 32'd0);
      tick();
      chk("final_idle", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pop_frame_stats

// File: doc/pop_frame_stats.md
Name: pop_frame_stats

Overview:
- Streaming statistics stage placed directly downstream of the count32 32-bit popcount block.
- Accepts 32-bit words over a valid/ready handshake; each frame ends on the word flagged in_last.
- Per word: counts set bits with an internal count32 instance, then registers the count.
- Per frame: accumulates total set bits, word count and maximum per-word count, then presents one result record over a valid/ready handshake.

Parameters:
- CNT_W, 16, width of the per-frame word counter (out_words).
- SUM_W, CNT_W+5, width of the per-frame set-bit sum (out_sum). Localparam; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  32  input word
- in_last  in  1  final word of frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  SUM_W  total set bits in frame
- out_words  out  CNT_W  words in frame
- out_max  out  6  largest per-word popcount in frame (0..32)
- out_overflow  out  1  word counter or sum saturated during frame

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0 except in_ready, which is 1 (state RUN). Accumulators and stage-1 registers are cleared.
- Reset mid-frame or mid-result drops all partial or pending data.
- Stage 1 (registered):
  - On accept (in_valid && in_ready), capture p1_cnt = count32(in_data) and p1_last = in_last, and set p1_valid = 1.
  - p1_valid clears on any cycle without an accept.
- Stage 2 (accumulate), when p1_valid:
  - sum += p1_cnt
  - words += 1
  - max = max(max, p1_cnt)
- Saturation:
  - words stops at 2^CNT_W-1.
  - sum stops at 2^SUM_W-1.
  - If either would exceed its limit, overflow is set (sticky for the frame).
- FSM states RUN, DRAIN, DONE:
  - RUN: in_ready = 1. Accepting a word with in_last = 1 moves to DRAIN.
  - DRAIN: in_ready = 0. Stage 1 folds the last word into the accumulators. Move to DONE the next cycle.
  - DONE: out_valid = 1 and in_ready = 0. Outputs are driven from the accumulators and held stable while out_ready = 0. When out_valid && out_ready: clear the accumulators and overflow, then go to RUN.
- Latency: last word accepted at edge t → out_valid high after edge t+2.
- Gaps: non-last words may arrive back-to-back or with gaps; in_valid low in RUN just idles.
- Back-to-back frames: the earliest first word of the next frame is accepted the cycle after the result handshake. Minimum 3 dead cycles between frames is accepted.
- Frame content: there is no empty frame, because in_last always travels with a word. A single-word frame is legal.
- in_data and in_last are ignored when in_valid = 0 or in_ready = 0.

Decomposition:
- Package pop_pkg holds:
  - WORD_W = 32 and POP_W = 6
  - state enum {RUN, DRAIN, DONE}
- Sub-module: the existing count32 popcount block, instantiated once combinationally on in_data.
- Everything else is flat in pop_frame_stats.

Test Plan:
- Basic frame: words 0x00000000, 0x00000001, 0xFFFFFFFF, 0xFFFF0000 back-to-back, in_last on the 4th, out_ready = 1 → out_sum = 49, out_words = 4, out_max = 32, out_overflow = 0; out_valid high exactly 2 edges after the last accept, for 1 cycle.
- Single-word frame: 0x0000000F with in_last = 1 → sum = 4, words = 1, max = 4; in_ready low during DRAIN/DONE.
- Backpressure: basic frame with out_ready held 0 for 5 cycles → out_valid stays 1, outputs are stable, in_ready = 0; after out_ready = 1, in_ready = 1 the next cycle.
- Back-to-back frames with in_valid gaps:
  - Frame A = {0xAAAAAAAA, 0x1} → sum 17, words 2, max 16.
  - Frame B = {0x80000000} → sum 1, words 1, max 1.
  - Check that no accumulation carries over from A into B.
- Overflow with CNT_W = 2 (SUM_W = 7): 5 words of 0xFFFFFFFF, last on the 5th → out_words = 3, out_sum = 127, out_max = 32, out_overflow = 1. The next frame {0x1} reports overflow = 0.
- Reset mid-frame: accept 2 words, assert rst_n = 0 for 1 cycle, then send frame {0x3 last} → sum = 2, words = 1, max = 2; no stale out_valid appears.
